// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt pending arbiter and its encoder.
package irq_pkg;
  localparam int REQ_W = 8;
  localparam int IDX_W = 3;

  typedef logic [REQ_W-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] req_idx_t;

  // Expand a 3-bit index into its 8-bit one-hot vector.
  function automatic req_vec_t onehot3(input req_idx_t idx);
    req_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/irq_pending_arbiter_if.sv
// Valid/ready grant channel carrying the selected request index.
interface irq_pending_arbiter_if;
  irq_pkg::req_idx_t out_idx;
  logic              out_valid;
  logic              out_ready;

  // Arbiter side presents the index; consumer side accepts it.
  modport master (output out_idx, output out_valid, input out_ready);
  modport slave  (input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/priority_encoder_8to3.sv
// Combinational 8-to-3 priority encoder; bit 7 has highest priority.
module priority_encoder_8to3
  import irq_pkg::*;
(
  input  req_vec_t in,
  output req_idx_t out,
  output logic     valid
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    out   = '0;
    valid = |in;
    for (int i = 0; i < REQ_W; i++) begin
      if (in[i]) out = req_idx_t'(i);
    end
  end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Sticky pending register with enable mask, registered valid/ready grant
// output and a saturating counter of requests lost to an already-pending bit.
module irq_pending_arbiter
  import irq_pkg::*;
#(
  parameter int DROP_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  req_vec_t                  req_in,
  input  req_vec_t                  mask_in,
  irq_pending_arbiter_if.master     out_if,
  output req_vec_t                  pending,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);

  req_vec_t              pending_reg, pending_next;
  req_idx_t              out_idx_reg, out_idx_next;
  logic                  out_valid_reg, out_valid_next;
  logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic                  accept;
  req_vec_t              clr;
  req_vec_t              lost;
  req_vec_t              cand;
  req_idx_t              enc_idx;
  logic                  enc_valid;
  logic [3:0]            lost_cnt;
  logic [DROP_CNT_W:0]   drop_sum;

  // Candidates come from the registered pending set, so a request arriving
  // this cycle is not eligible until the following edge.
  priority_encoder_8to3 u_enc (
    .in    (cand),
    .out   (enc_idx),
    .valid (enc_valid)
  );

  // Next-state logic for pending, grant register and lost-request counter.
  always_comb begin
    accept         = out_valid_reg && out_if.out_ready;
    clr            = accept ? onehot3(out_idx_reg) : '0;
    // A request landing on the bit being cleared re-arms it rather than dropping.
    pending_next   = (pending_reg & ~clr) | req_in;
    lost           = req_in & pending_reg & ~clr;
    cand           = pending_reg & ~clr & mask_in;

    lost_cnt = '0;
    for (int i = 0; i < REQ_W; i++) begin
      lost_cnt = lost_cnt + 4'(lost[i]);
    end
    drop_sum      = {1'b0, drop_cnt_reg} + (DROP_CNT_W+1)'(lost_cnt);
    drop_cnt_next = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];

    // A presented index stays put while stalled, even if mask or pending move.
    out_idx_next   = out_idx_reg;
    out_valid_next = out_valid_reg;
    if (!out_valid_reg || accept) begin
      out_valid_next = enc_valid;
      if (enc_valid) out_idx_next = enc_idx;
    end
  end

  // State registers with synchronous reset; requests during reset are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg   <= '0;
      out_idx_reg   <= '0;
      out_valid_reg <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      pending_reg   <= pending_next;
      out_idx_reg   <= out_idx_next;
      out_valid_reg <= out_valid_next;
      drop_cnt_reg  <= drop_cnt_next;
    end
  end

  assign out_if.out_idx   = out_idx_reg;
  assign out_if.out_valid = out_valid_reg;
  assign pending          = pending_reg;
  assign drop_cnt         = drop_cnt_reg;

endmodule
